quadrature_decoder: RTL and testbench
=====================================

# quadrature_decoder

Multi-channel debounced quadrature decoder for mechanical or optical rotary encoders (EC11 and similar). Each channel synchronises and filters its A/B inputs, decodes full Gray-code quadrature at a selectable resolution, and emits single-cycle cw/ccw step flags. Each channel also keeps a signed position counter and a sticky error flag for illegal transitions. It sits between encoder pins with external pull-ups and user-interface or motor-control logic that needs either step events or an absolute position.

## Interface
- CHANNELS, 1: number of independent encoder channels (≥1).
- COUNT_WIDTH, 16: width of each signed position counter (≥2).
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before a new A/B state is accepted; 0 bypasses the filter.
- RESOLUTION, 1: steps per full quadrature cycle; legal values are 1, 2 and 4. Any other value is an elaboration error.
- WRAP, 1: 1 means the position wraps modulo 2^COUNT_WIDTH; 0 means it saturates.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_a  in  CHANNELS  raw encoder A inputs, asynchronous to clk.
- in_b  in  CHANNELS  raw encoder B inputs, asynchronous to clk.
- clear  in  CHANNELS  synchronous per-channel clear of position and error.
- out_cw  out  CHANNELS  one-cycle clockwise step flag.
- out_ccw  out  CHANNELS  one-cycle counter-clockwise step flag.
- position  out  CHANNELS*COUNT_WIDTH  signed counts; channel i occupies bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- error  out  CHANNELS  sticky illegal-transition flag.

## Operation
- Reset values: out_cw=0, out_ccw=0, position=0, error=0. Synchronisers=0, debounce counters=0, reference-valid flag=0.
- Per channel, each input passes through a 2-flop synchroniser.
- Debounce filter (DEBOUNCE_CYCLES>0):
  - The candidate is the synchronised {a,b}.
  - If the candidate differs from the accepted state, a counter increments each cycle the candidate stays the same.
  - Any change of the candidate restarts the counter at 0.
  - When the count reaches DEBOUNCE_CYCLES, the candidate becomes the accepted state.
  - If the candidate returns to the accepted state, the counter is cleared.
- Reference: the first accepted state after reset is loaded as the reference and produces no step, no error and no position change.
- Gray order, with state written as {a,b}:
  - Clockwise: 00→10→11→01→00.
  - Counter-clockwise is the reverse order.
- Legal transition (one bit changes):
  - The direction is taken from the order above and the reference updates.
  - A step is emitted when the new state is a step state:
    - RESOLUTION=4: every state.
    - RESOLUTION=2: states 00 and 11.
    - RESOLUTION=1: state 00 only.
  - A move that reverses into a step state emits a step in the reverse direction, so jitter about a detent nets zero.
- Illegal transition (both bits change in one accepted update): error←1, no step, reference←new state.
- Step effects: out_cw or out_ccw pulses for exactly one cycle. Position changes by +1 (cw) or −1 (ccw).
- Wrap and saturation:
  - WRAP=1: +1 from the maximum gives the minimum, and vice versa.
  - WRAP=0: position holds at the limit while the step flag still pulses.
- clear:
  - clear[i] has priority in the same cycle: position←0 and error←0.
  - A coincident step flag still pulses, but the count for that step is discarded.
- Channels are fully independent. out_cw and out_ccw of one channel are never high together.

## Timing
- All outputs are registered.
- With DEBOUNCE_CYCLES=0, an input edge that meets setup before edge k gives out_cw/out_ccw high and position updated after edge k+2. Latency is 3 clocks.
- With DEBOUNCE_CYCLES=N, latency is 3+N clocks, provided the input is stable for the whole window.
- Steps arrive at most once per accepted transition. The minimum input dwell per state is N+1 cycles; shorter glitches are rejected.
- Reset asserted mid-operation clears all state immediately. After release, the first accepted state is taken as the reference again.
- A clear asserted for one cycle takes effect at the next rising edge.

## Test plan
- RESOLUTION=1, DEBOUNCE=0, idle at 00:
  - Drive 10,11,01,00, each held 4 cycles → exactly one out_cw pulse, 3 cycles after 00 appears; position=1.
  - Same with the reverse order → one out_ccw pulse; position=−1.
- RESOLUTION=4: drive 8 clockwise transitions, then 3 counter-clockwise → 8 cw pulses and 3 ccw pulses; position=5.
- DEBOUNCE_CYCLES=4: a 3-cycle glitch on A → no step and no state change. A 6-cycle stable change → accepted, with latency of 7 cycles.
- Illegal transition:
  - Jump 00→11 → error=1, position unchanged.
  - A subsequent legal transition still counts.
  - clear → error=0, position=0.
- Limits at COUNT_WIDTH=4:
  - WRAP=1: 8 cw steps from 0 → position=−8 (0x8).
  - WRAP=0: 10 cw steps → position stays at 7 while 10 cw pulses are seen.
- CHANNELS=2:
  - Channel 0 turns cw while channel 1 turns ccw, with rst pulsed mid-sequence → all outputs are 0 during reset.
  - After release, the first state produces no step, and each channel then counts only its own transitions.

Source files
------------

// File: rtl/quadrature_decoder.sv
// Multi-channel debounced quadrature decoder: sync, optional debounce filter,
// Gray-code step decode at 1x/2x/4x resolution, signed position and sticky error.

module qd_channel #(
  parameter int COUNT_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int RESOLUTION      = 1,
  parameter int WRAP            = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_a,
  input  logic                   i_b,
  input  logic                   i_clear,
  input  logic                   i_sv,
  output logic                   o_cw,
  output logic                   o_ccw,
  output logic [COUNT_WIDTH-1:0] o_pos,
  output logic                   o_err
);

  localparam logic [COUNT_WIDTH-1:0] PMAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic [COUNT_WIDTH-1:0] PMIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

  logic [1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_a, i_b};
      r_sync2 <= r_sync1;
    end
  end

  logic [1:0] w_acc;
  logic       w_acc_vld;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_acc     = r_sync2;
      assign w_acc_vld = i_sv;
    end else begin : g_filt
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES);
      logic [CW-1:0] r_cnt, w_run;
      logic [1:0]    r_prev, r_acc;
      logic          r_acc_vld;

      // w_run is the number of consecutive cycles the candidate has been seen, this one included
      assign w_run = (r_sync2 == r_prev) ? r_cnt + CW'(1) : CW'(1);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt     <= '0;
          r_prev    <= '0;
          r_acc     <= '0;
          r_acc_vld <= 1'b0;
        end else if (i_sv) begin
          r_prev <= r_sync2;
          if (r_acc_vld && (r_sync2 == r_acc)) begin
            r_cnt <= '0;
          end else if (w_run >= LIM) begin
            r_acc     <= r_sync2;
            r_acc_vld <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_run;
          end
        end
      end

      assign w_acc     = r_acc;
      assign w_acc_vld = r_acc_vld;
    end
  endgenerate

  // Clockwise successor in the Gray order 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] f_cw_next(input logic [1:0] s);
    case (s)
      2'b00:   f_cw_next = 2'b10;
      2'b10:   f_cw_next = 2'b11;
      2'b11:   f_cw_next = 2'b01;
      default: f_cw_next = 2'b00;
    endcase
  endfunction

  logic [1:0]             r_ref;
  logic                   r_ref_vld;
  logic                   r_cw, r_ccw, r_err;
  logic [COUNT_WIDTH-1:0] r_pos;
  logic                   w_chg, w_fwd, w_rev, w_bad, w_stp, w_up, w_dn;
  logic [COUNT_WIDTH-1:0] w_inc, w_dec;

  always_comb begin
    w_chg = w_acc_vld && r_ref_vld && (w_acc != r_ref);
    w_fwd = w_chg && (w_acc == f_cw_next(r_ref));
    w_rev = w_chg && (r_ref == f_cw_next(w_acc));
    w_bad = w_chg && !w_fwd && !w_rev;
    if (RESOLUTION == 4)      w_stp = 1'b1;
    else if (RESOLUTION == 2) w_stp = (w_acc == 2'b00) || (w_acc == 2'b11);
    else                      w_stp = (w_acc == 2'b00);
    w_up  = w_fwd && w_stp;
    w_dn  = w_rev && w_stp;
    w_inc = (WRAP == 0 && r_pos == PMAX) ? r_pos : r_pos + COUNT_WIDTH'(1);
    w_dec = (WRAP == 0 && r_pos == PMIN) ? r_pos : r_pos - COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
      r_cw      <= 1'b0;
      r_ccw     <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_cw  <= w_up;
      r_ccw <= w_dn;
      if (w_acc_vld) begin
        r_ref     <= w_acc;
        r_ref_vld <= 1'b1;
      end
      // clear wins over both the count and a coincident illegal transition
      if (i_clear) begin
        r_pos <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_bad) r_err <= 1'b1;
        if (w_up)      r_pos <= w_inc;
        else if (w_dn) r_pos <= w_dec;
      end
    end
  end

  assign o_cw  = r_cw;
  assign o_ccw = r_ccw;
  assign o_pos = r_pos;
  assign o_err = r_err;

endmodule

module quadrature_decoder #(
  parameter int CHANNELS        = 1,
  parameter int COUNT_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int RESOLUTION      = 1,
  parameter int WRAP            = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             in_a,
  input  logic [CHANNELS-1:0]             in_b,
  input  logic [CHANNELS-1:0]             clear,
  output logic [CHANNELS-1:0]             out_cw,
  output logic [CHANNELS-1:0]             out_ccw,
  output logic [CHANNELS*COUNT_WIDTH-1:0] position,
  output logic [CHANNELS-1:0]             error
);

  generate
    if (!(RESOLUTION == 1 || RESOLUTION == 2 || RESOLUTION == 4)) begin : g_bad_res
      $error("quadrature_decoder: RESOLUTION must be 1, 2 or 4");
    end
    if (CHANNELS < 1 || COUNT_WIDTH < 2 || DEBOUNCE_CYCLES < 0) begin : g_bad_size
      $error("quadrature_decoder: illegal CHANNELS/COUNT_WIDTH/DEBOUNCE_CYCLES");
    end
  endgenerate

  // Synchroniser contents are only real input samples two cycles after reset release
  logic [1:0] r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fill <= '0;
    else     r_fill <= {r_fill[0], 1'b1};
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      qd_channel #(
        .COUNT_WIDTH     (COUNT_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESOLUTION      (RESOLUTION),
        .WRAP            (WRAP)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_a     (in_a[gi]),
        .i_b     (in_b[gi]),
        .i_clear (clear[gi]),
        .i_sv    (r_fill[1]),
        .o_cw    (out_cw[gi]),
        .o_ccw   (out_ccw[gi]),
        .o_pos   (position[gi*COUNT_WIDTH +: COUNT_WIDTH]),
        .o_err   (error[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomised and directed bench: four decoder configurations share the same
// pins and are checked every cycle against an event-level reference model.

module tb_quadrature_decoder;

  logic clk, rst;
  logic [1:0] in_a, in_b, clear;
  logic [1:0] cw0, cw1, cw2, cw3, ccw0, ccw1, ccw2, ccw3, err0, err1, err2, err3;
  logic [31:0] pos0;
  logic [7:0]  pos1, pos2, pos3;

  localparam int P_W   [4] = '{16, 4, 4, 4};
  localparam int P_DEB [4] = '{0, 0, 4, 0};
  localparam int P_RES [4] = '{1, 4, 2, 4};
  localparam int P_WRP [4] = '{1, 1, 0, 0};

  quadrature_decoder #(.CHANNELS(2), .COUNT_WIDTH(16), .DEBOUNCE_CYCLES(0), .RESOLUTION(1), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clear(clear),
    .out_cw(cw0), .out_ccw(ccw0), .position(pos0), .error(err0));
  quadrature_decoder #(.CHANNELS(2), .COUNT_WIDTH(4), .DEBOUNCE_CYCLES(0), .RESOLUTION(4), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clear(clear),
    .out_cw(cw1), .out_ccw(ccw1), .position(pos1), .error(err1));
  quadrature_decoder #(.CHANNELS(2), .COUNT_WIDTH(4), .DEBOUNCE_CYCLES(4), .RESOLUTION(2), .WRAP(0)) u2 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clear(clear),
    .out_cw(cw2), .out_ccw(ccw2), .position(pos2), .error(err2));
  quadrature_decoder #(.CHANNELS(2), .COUNT_WIDTH(4), .DEBOUNCE_CYCLES(0), .RESOLUTION(4), .WRAP(0)) u3 (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .clear(clear),
    .out_cw(cw3), .out_ccw(ccw3), .position(pos3), .error(err3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] d_cw(input int d);
    case (d) 0: return cw0; 1: return cw1; 2: return cw2; default: return cw3; endcase
  endfunction
  function automatic logic [1:0] d_ccw(input int d);
    case (d) 0: return ccw0; 1: return ccw1; 2: return ccw2; default: return ccw3; endcase
  endfunction
  function automatic logic [1:0] d_err(input int d);
    case (d) 0: return err0; 1: return err1; 2: return err2; default: return err3; endcase
  endfunction
  function automatic int d_pos(input int d, input int c);
    case (d)
      0:       return int'(pos0[c*16 +: 16]);
      1:       return int'(pos1[c*4 +: 4]);
      2:       return int'(pos2[c*4 +: 4]);
      default: return int'(pos3[c*4 +: 4]);
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic int gidx(input logic [1:0] s);
    case (s) 2'b00: return 0; 2'b10: return 1; 2'b11: return 2; default: return 3; endcase
  endfunction
  function automatic bit is_step(input int res, input logic [1:0] s);
    if (res == 4) return 1'b1;
    if (res == 2) return (gidx(s) % 2) == 0;
    return gidx(s) == 0;
  endfunction
  function automatic int bump(input int p, input int dl, input int w, input int wrap);
    int lim, q;
    lim = 1 << (w - 1);
    q = p + dl;
    if (wrap != 0) begin
      if (q >= lim) q -= 2 * lim;
      else if (q < -lim) q += 2 * lim;
    end else begin
      if (q >= lim) q = lim - 1;
      if (q < -lim) q = -lim;
    end
    return q;
  endfunction

  int         m_n;
  logic [1:0] m_hist [2][$];
  int         m_run [2];
  logic [1:0] m_prev [2];
  logic [1:0] m_acc [4][2];
  bit         m_accv [4][2];
  logic [1:0] m_ref [4][2];
  bit         m_refv [4][2];
  bit         m_cw [4][2];
  bit         m_ccw [4][2];
  bit         m_err [4][2];
  int         m_pos [4][2];

  initial begin
    logic [1:0] cand [2];
    logic [1:0] va;
    bit sv, vv, up, dn, bad;
    int dl;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_n = 0;
        for (int c = 0; c < 2; c++) begin
          m_hist[c].delete();
          m_run[c] = 0;
          m_prev[c] = 2'b00;
          for (int d = 0; d < 4; d++) begin
            m_acc[d][c] = 2'b00; m_accv[d][c] = 0; m_ref[d][c] = 2'b00; m_refv[d][c] = 0;
            m_cw[d][c] = 0; m_ccw[d][c] = 0; m_err[d][c] = 0; m_pos[d][c] = 0;
          end
        end
      end else begin
        m_n++;
        sv = (m_n >= 3);
        for (int c = 0; c < 2; c++) begin
          m_hist[c].push_back({in_a[c], in_b[c]});
          if (m_hist[c].size() > 3) void'(m_hist[c].pop_front());
          cand[c] = m_hist[c][0];
          if (sv) begin
            m_run[c] = (m_run[c] > 0 && cand[c] == m_prev[c]) ? m_run[c] + 1 : 1;
            m_prev[c] = cand[c];
          end
        end
        for (int d = 0; d < 4; d++) begin
          for (int c = 0; c < 2; c++) begin
            if (P_DEB[d] == 0) begin va = cand[c]; vv = sv; end
            else begin va = m_acc[d][c]; vv = m_accv[d][c]; end
            up = 0; dn = 0; bad = 0;
            if (vv) begin
              if (m_refv[d][c] && va != m_ref[d][c]) begin
                dl = (gidx(va) - gidx(m_ref[d][c]) + 4) % 4;
                if (dl == 2) bad = 1;
                else if (is_step(P_RES[d], va)) begin
                  up = (dl == 1);
                  dn = (dl == 3);
                end
              end
              m_ref[d][c] = va;
              m_refv[d][c] = 1;
            end
            m_cw[d][c] = up;
            m_ccw[d][c] = dn;
            if (clear[c]) begin
              m_pos[d][c] = 0;
              m_err[d][c] = 0;
            end else begin
              if (bad) m_err[d][c] = 1;
              if (up) m_pos[d][c] = bump(m_pos[d][c], 1, P_W[d], P_WRP[d]);
              if (dn) m_pos[d][c] = bump(m_pos[d][c], -1, P_W[d], P_WRP[d]);
            end
            if (P_DEB[d] > 0 && sv && m_run[c] >= P_DEB[d] &&
                (!m_accv[d][c] || cand[c] != m_acc[d][c])) begin
              m_acc[d][c] = cand[c];
              m_accv[d][c] = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and pulse counters ----------------
  int pc_cw [4];
  int pc_ccw [4];

  initial begin
    logic [1:0] vcw, vccw, verr;
    int mask;
    for (int d = 0; d < 4; d++) begin pc_cw[d] = 0; pc_ccw[d] = 0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        vcw = d_cw(d); vccw = d_ccw(d); verr = d_err(d);
        pc_cw[d] += int'(vcw[0]);
        pc_ccw[d] += int'(vccw[0]);
        mask = (1 << P_W[d]) - 1;
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("cw u%0d ch%0d", d, c), vcw[c], m_cw[d][c]);
          chk($sformatf("ccw u%0d ch%0d", d, c), vccw[c], m_ccw[d][c]);
          chk($sformatf("err u%0d ch%0d", d, c), verr[c], m_err[d][c]);
          chk($sformatf("pos u%0d ch%0d", d, c), d_pos(d, c), m_pos[d][c] & mask);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] SEQ [4];
  logic [1:0] cur [2];

  task automatic set_in(input logic [1:0] s0, input logic [1:0] s1, input int hold);
    @(negedge clk);
    in_a = {s1[1], s0[1]};
    in_b = {s1[0], s0[0]};
    cur[0] = s0;
    cur[1] = s1;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic step0(input int k, input int hold);
    set_in(SEQ[(gidx(cur[0]) + k) % 4], cur[1], hold);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 2'b11;
    @(negedge clk); clear = 2'b00;
    @(negedge clk);
  endtask

  task automatic chk_zero_all(input string tag);
    logic [1:0] v;
    for (int d = 0; d < 4; d++) begin
      v = d_cw(d) | d_ccw(d) | d_err(d);
      chk($sformatf("%s flags u%0d", tag, d), v, 0);
      chk($sformatf("%s pos u%0d", tag, d), d_pos(d, 0) + d_pos(d, 1), 0);
    end
  endtask

  initial begin
    int l0, l2, s_cw, s_ccw, s3;
    logic [1:0] e;
    SEQ[0] = 2'b00; SEQ[1] = 2'b10; SEQ[2] = 2'b11; SEQ[3] = 2'b01;
    rst = 1'b1; in_a = 2'b00; in_b = 2'b00; clear = 2'b00;
    cur[0] = 2'b00; cur[1] = 2'b00;
    repeat (3) @(negedge clk);
    chk_zero_all("reset");
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);

    // one full cycle: channel 0 clockwise, channel 1 counter-clockwise
    for (int i = 1; i <= 3; i++) set_in(SEQ[i], SEQ[4 - i], 6);
    s_cw = pc_cw[0];
    @(negedge clk);
    in_a = 2'b00; in_b = 2'b00; cur[0] = 2'b00; cur[1] = 2'b00;
    l0 = 0; l2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cw0[0] && l0 == 0) l0 = i;
      if (cw2[0] && l2 == 0) l2 = i;
    end
    chk("latency res1", l0, 3);
    chk("latency deb4", l2, 7);
    chk("res1 cw pulses", pc_cw[0] - s_cw, 1);
    chk("res1 pos ch0", d_pos(0, 0), 1);
    chk("res1 pos ch1", d_pos(0, 1), 16'hFFFF);
    chk("res4 pos ch0", d_pos(1, 0), 4);
    chk("res4 pos ch1", d_pos(1, 1), 4'hC);
    chk("res2 pos ch0", d_pos(2, 0), 2);
    chk("res2 pos ch1", d_pos(2, 1), 4'hE);

    // 3-cycle glitch on A is rejected by the debounced instance
    s_cw = pc_cw[2]; s_ccw = pc_ccw[2];
    set_in(2'b10, 2'b00, 3);
    set_in(2'b00, 2'b00, 10);
    chk("glitch pos", d_pos(2, 0), 2);
    chk("glitch pulses", (pc_cw[2] - s_cw) + (pc_ccw[2] - s_ccw), 0);

    // illegal jump, then a legal move, then clear
    set_in(2'b11, 2'b00, 10);
    e = err1 & err2;
    chk("illegal err", e[0], 1);
    chk("illegal pos", d_pos(1, 0), 4);
    set_in(2'b01, 2'b00, 6);
    chk("after illegal pos", d_pos(1, 0), 5);
    pulse_clear();
    chk("clear err", err1[0], 0);
    chk("clear pos", d_pos(1, 0), 0);
    chk("clear pos ch1", d_pos(0, 1), 0);

    // 8 cw then 3 ccw at 4x resolution
    s_cw = pc_cw[1]; s_ccw = pc_ccw[1];
    repeat (8) step0(1, 6);
    repeat (3) step0(3, 6);
    chk("res4 cw count", pc_cw[1] - s_cw, 8);
    chk("res4 ccw count", pc_ccw[1] - s_ccw, 3);
    chk("res4 net pos", d_pos(1, 0), 5);

    // wrap and saturation at COUNT_WIDTH=4
    pulse_clear();
    s3 = pc_cw[3];
    repeat (8) step0(1, 6);
    chk("wrap pos", d_pos(1, 0), 4'h8);
    repeat (2) step0(1, 6);
    chk("sat pos", d_pos(3, 0), 7);
    chk("sat pulses", pc_cw[3] - s3, 10);

    // reset mid-motion
    for (int i = 0; i < 2; i++)
      set_in(SEQ[(gidx(cur[0]) + 1) % 4], SEQ[(gidx(cur[1]) + 3) % 4], 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_all("midrst");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++)
      set_in(SEQ[(gidx(cur[0]) + 1) % 4], SEQ[(gidx(cur[1]) + 3) % 4], 6);

    // random walk with glitches, illegal jumps, clears and resets
    for (int it = 0; it < 400; it++) begin
      logic [1:0] nx [2];
      int dw;
      for (int c = 0; c < 2; c++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r < 7)       nx[c] = SEQ[(gidx(cur[c]) + 1) % 4];
        else if (r < 13) nx[c] = SEQ[(gidx(cur[c]) + 3) % 4];
        else if (r < 14) nx[c] = SEQ[(gidx(cur[c]) + 2) % 4];
        else             nx[c] = cur[c];
      end
      dw = $urandom_range(1, 8);
      @(negedge clk);
      in_a = {nx[1][1], nx[0][1]};
      in_b = {nx[1][0], nx[0][0]};
      cur[0] = nx[0]; cur[1] = nx[1];
      clear = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
      for (int k = 1; k < dw; k++) begin
        @(negedge clk);
        clear = 2'b00;
      end
    end
    @(negedge clk);
    clear = 2'b00;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
